// File: rtl/syn_seq_pkg.sv
// Shared types and defaults for the synaptic-row update sequencer.
// State encoding, row geometry and wait-counter sizing helper.
package syn_seq_pkg;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int INPUT_NEURON_DEF   = 784;
  localparam int OUTPUT_NEURON_DEF  = 256;
  localparam int POST_PAR_DEF       = 4;
  localparam int WORDS_PER_ROW      =
    OUTPUT_NEURON_DEF / POST_PAR_DEF;
  localparam int UPDATE_LATENCY_DEF = 1;
  localparam int LAT_W = cnt_w(UPDATE_LATENCY_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_HOLD,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/syn_update_sequencer_if.sv
// Request and SRAM-control bundle of the update sequencer.
// master = sequencer side, slave = controller / monitor side.
interface syn_update_sequencer_if #(
  parameter int PRE_W  = 10,
  parameter int POST_W = 10,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              SPI_GATE_ACTIVITY_sync;
  logic              START;
  logic [PRE_W-1:0]  PRE_NEUR_ADDR;
  logic [DATA_W-1:0] PRE_NEUR_S_CNT;
  logic              CTRL_SYNARRAY_CS;
  logic              CTRL_SYNARRAY_WE;
  logic [ADDR_W-1:0] CTRL_SYNARRAY_ADDR;
  logic [POST_W-1:0] CTRL_POST_NEURON_ADDRESS;
  logic              BUSY;
  logic              DONE;

  modport master (
    input  SPI_GATE_ACTIVITY_sync, START,
    input  PRE_NEUR_ADDR, PRE_NEUR_S_CNT,
    output CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE,
    output CTRL_SYNARRAY_ADDR,
    output CTRL_POST_NEURON_ADDRESS,
    output BUSY, DONE
  );

  modport slave (
    output SPI_GATE_ACTIVITY_sync, START,
    output PRE_NEUR_ADDR, PRE_NEUR_S_CNT,
    input  CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE,
    input  CTRL_SYNARRAY_ADDR,
    input  CTRL_POST_NEURON_ADDRESS,
    input  BUSY, DONE
  );
endinterface

// File: rtl/syn_addr_gen.sv
// Row base latch, word counter and SRAM/post address stepping.
// The row multiply happens only on load; words advance by increment.
module syn_addr_gen #(
  parameter int PRE_W  = 10,
  parameter int POST_W = 10,
  parameter int ADDR_W = 16,
  parameter int WPR    = 64,
  parameter int PAR    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              clr_i,
  input  logic [PRE_W-1:0]  row_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [POST_W-1:0] post_o,
  output logic              last_o
);
  localparam int WW = (WPR > 1) ? $clog2(WPR) : 1;

  logic [WW-1:0]     word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [POST_W-1:0] post_q, post_d;

  always_comb begin
    word_d = word_q;
    addr_d = addr_q;
    post_d = post_q;
    if (load_i) begin
      word_d = '0;
      post_d = '0;
      addr_d = ADDR_W'(32'(row_i) * 32'(WPR));
    end else if (step_i) begin
      word_d = word_q + WW'(1);
      addr_d = addr_q + ADDR_W'(1);
      post_d = post_q + POST_W'(PAR);
    end else if (clr_i) begin
      word_d = '0;
      post_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      addr_q <= '0;
      post_q <= '0;
    end else begin
      word_q <= word_d;
      addr_q <= addr_d;
      post_q <= post_d;
    end
  end

  assign addr_o = addr_q;
  assign post_o = post_q;
  assign last_o = (word_q == WW'(WPR - 1));
endmodule

// File: rtl/syn_update_sequencer.sv
// Walks one pre-neuron row of the synaptic SRAM as read/wait/write.
// Optional SYN_SEQ_SKIP_ZERO_EN: rows with zero spike count are skipped.
module syn_update_sequencer
  import syn_seq_pkg::*;
#(
  parameter int INPUT_NEURON         = INPUT_NEURON_DEF,
  parameter int OUTPUT_NEURON        = OUTPUT_NEURON_DEF,
  parameter int POST_NEUR_PARALLEL   = POST_PAR_DEF,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16,
  parameter int UPDATE_LATENCY       = UPDATE_LATENCY_DEF
) (
  input logic CLK,
  input logic RST,
  syn_update_sequencer_if.master seq_io
);
  localparam int WPR = OUTPUT_NEURON / POST_NEUR_PARALLEL;
  localparam int LW  = cnt_w(UPDATE_LATENCY);

  seq_state_e st_q, st_d;
  logic [LW-1:0] lat_q, lat_d;
  logic cs_q, cs_d, we_q, we_d;
  logic busy_q, busy_d, done_q, done_d;
  logic load, step, clr, last;
  logic row_ok, skip;

  assign row_ok = 32'(seq_io.PRE_NEUR_ADDR) < INPUT_NEURON;

`ifdef SYN_SEQ_SKIP_ZERO_EN
  assign skip = (seq_io.PRE_NEUR_S_CNT == '0);
`else
  logic unused_cnt;
  assign unused_cnt = ^seq_io.PRE_NEUR_S_CNT;
  assign skip = 1'b0;
`endif

  always_comb begin
    st_d  = st_q;
    lat_d = lat_q;
    load  = 1'b0;
    step  = 1'b0;
    clr   = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (seq_io.START &&
            !seq_io.SPI_GATE_ACTIVITY_sync) begin
          if (!row_ok || skip) begin
            st_d = S_DONE;
          end else begin
            st_d = S_RD;
            load = 1'b1;
          end
        end
      end
      S_RD: begin
        if (UPDATE_LATENCY == 0) begin
          st_d = S_WR;
        end else begin
          st_d  = S_WAIT;
          lat_d = '0;
        end
      end
      S_WAIT: begin
        if (lat_q == LW'(UPDATE_LATENCY - 1)) st_d = S_WR;
        else lat_d = lat_q + LW'(1);
      end
      S_WR: begin
        if (last) begin
          st_d = S_DONE;
        end else begin
          step = 1'b1;
          // gate is honoured only at the word boundary
          st_d = seq_io.SPI_GATE_ACTIVITY_sync ?
                 S_HOLD : S_RD;
        end
      end
      S_HOLD: begin
        if (!seq_io.SPI_GATE_ACTIVITY_sync) st_d = S_RD;
      end
      S_DONE: begin
        st_d = S_IDLE;
        clr  = 1'b1;
      end
      default: st_d = S_IDLE;
    endcase
    cs_d   = (st_d == S_RD) || (st_d == S_WR);
    we_d   = (st_d == S_WR);
    busy_d = (st_d != S_IDLE);
    done_d = (st_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q   <= S_IDLE;
      lat_q  <= '0;
      cs_q   <= 1'b0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      lat_q  <= lat_d;
      cs_q   <= cs_d;
      we_q   <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  syn_addr_gen #(
    .PRE_W  (PRE_NEUR_ADDR_WIDTH),
    .POST_W (POST_NEUR_ADDR_WIDTH),
    .ADDR_W (SYN_ARRAY_ADDR_WIDTH),
    .WPR    (WPR),
    .PAR    (POST_NEUR_PARALLEL)
  ) u_addr (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (load),
    .step_i (step),
    .clr_i  (clr),
    .row_i  (seq_io.PRE_NEUR_ADDR),
    .addr_o (seq_io.CTRL_SYNARRAY_ADDR),
    .post_o (seq_io.CTRL_POST_NEURON_ADDRESS),
    .last_o (last)
  );

  assign seq_io.CTRL_SYNARRAY_CS = cs_q;
  assign seq_io.CTRL_SYNARRAY_WE = we_q;
  assign seq_io.BUSY             = busy_q;
  assign seq_io.DONE             = done_q;
endmodule

// File: tb/tb_syn_update_sequencer.sv
// Bench for syn_update_sequencer: row-walk model, random gate/start.
// Build with SYN_SEQ_SKIP_ZERO_EN to exercise the zero-count skip.
module tb_syn_update_sequencer;
  import syn_seq_pkg::*;

  localparam int L   = UPDATE_LATENCY_DEF;
  localparam int WPR = WORDS_PER_ROW;
  localparam int PAR = POST_PAR_DEF;
  localparam int NIN = INPUT_NEURON_DEF;
`ifdef SYN_SEQ_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  syn_update_sequencer_if bus ();

  syn_update_sequencer dut (
    .CLK    (clk),
    .RST    (rst),
    .seq_io (bus)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, wr_cnt = 0;
  int last_rd = 0, first_rd = 0, first_post = 0;
  int last_wr_addr = 0, last_wr_post = 0, last_wr_cyc = 0;
  bit first_flag = 1'b0;

  // row-level model: which word, which phase of it, parked or not
  int m_st = 0, m_word = 0, m_phase = 0, m_base = 0;
  bit m_hold = 1'b0, m_valid = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0;
      m_hold = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_st)
        0: if (bus.START && !bus.SPI_GATE_ACTIVITY_sync) begin
          if (int'(bus.PRE_NEUR_ADDR) >= NIN ||
              (SKIP && bus.PRE_NEUR_S_CNT == 0)) begin
            m_st = 2;
          end else begin
            m_st = 1;
            m_word = 0;
            m_phase = 0;
            m_hold = 1'b0;
            m_base = int'(bus.PRE_NEUR_ADDR) * WPR;
          end
        end
        1: begin
          if (m_hold) begin
            if (!bus.SPI_GATE_ACTIVITY_sync) begin
              m_hold = 1'b0;
              m_phase = 0;
            end
          end else if (m_phase < L + 1) begin
            m_phase++;
          end else if (m_word == WPR - 1) begin
            m_st = 2;
          end else begin
            m_word++;
            m_phase = 0;
            m_hold = bus.SPI_GATE_ACTIVITY_sync;
          end
        end
        default: m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      bit e_cs, e_we;
      e_cs = (m_st == 1) && !m_hold &&
             (m_phase == 0 || m_phase == L + 1);
      e_we = (m_st == 1) && !m_hold && (m_phase == L + 1);
      chk("cs", bus.CTRL_SYNARRAY_CS, e_cs);
      chk("we", bus.CTRL_SYNARRAY_WE, e_we);
      chk("busy", bus.BUSY, m_st != 0);
      chk("done", bus.DONE, m_st == 2);
      if (e_cs) begin
        chk("addr", bus.CTRL_SYNARRAY_ADDR, m_base + m_word);
        chk("post", bus.CTRL_POST_NEURON_ADDRESS, m_word * PAR);
      end
      if (bus.CTRL_SYNARRAY_CS && !bus.CTRL_SYNARRAY_WE) begin
        last_rd = int'(bus.CTRL_SYNARRAY_ADDR);
        if (!first_flag) begin
          first_rd = int'(bus.CTRL_SYNARRAY_ADDR);
          first_post = int'(bus.CTRL_POST_NEURON_ADDRESS);
          first_flag = 1'b1;
        end
      end
      if (bus.CTRL_SYNARRAY_WE) begin
        chk("we_has_cs", bus.CTRL_SYNARRAY_CS, 1);
        chk("wr_eq_rd", bus.CTRL_SYNARRAY_ADDR, last_rd);
        wr_cnt++;
        last_wr_addr = int'(bus.CTRL_SYNARRAY_ADDR);
        last_wr_post = int'(bus.CTRL_POST_NEURON_ADDRESS);
        last_wr_cyc = cyc;
      end
      if (bus.DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // mode 0 plain, 1 gate window, 2 re-start, 3 random, 4 reset
  task automatic run_row(input int row, input int cnt,
                         input int mode,
                         output int lat, output int nwr);
    int d0, w0, s;
    bit fin;
    d0 = done_cnt;
    w0 = wr_cnt;
    first_flag = 1'b0;
    fin = 1'b0;
    s = cyc;
    bus.START = 1'b1;
    bus.PRE_NEUR_ADDR = 10'(row);
    bus.PRE_NEUR_S_CNT = 8'(cnt);
    bus.SPI_GATE_ACTIVITY_sync = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      tick();
      if (done_cnt != d0) begin
        fin = 1'b1;
        break;
      end
      if (mode == 4 && k == 41) begin
        rst = 1'b0;
        fin = 1'b1;
        break;
      end
      bus.START = 1'b0;
      case (mode)
        1: bus.SPI_GATE_ACTIVITY_sync = (k >= 10 && k <= 20);
        2: if (k == 50) begin
          bus.START = 1'b1;
          bus.PRE_NEUR_ADDR = 10'd7;
        end
        3: begin
          bus.SPI_GATE_ACTIVITY_sync = ($urandom_range(0, 3) == 0);
          if ($urandom_range(0, 15) == 0) begin
            bus.START = 1'b1;
            bus.PRE_NEUR_ADDR = 10'($urandom_range(0, 799));
          end
        end
        4: rst = (k == 40);
        default: ;
      endcase
    end
    bus.START = 1'b0;
    bus.SPI_GATE_ACTIVITY_sync = 1'b0;
    if (!fin) chk("done_timeout", 0, 1);
    lat = done_cyc - s;
    nwr = wr_cnt - w0;
  endtask

  int lat, nwr, d_before;

  initial begin
    bus.START = 1'b0;
    bus.SPI_GATE_ACTIVITY_sync = 1'b0;
    bus.PRE_NEUR_ADDR = '0;
    bus.PRE_NEUR_S_CNT = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cs", bus.CTRL_SYNARRAY_CS, 0);
    chk("rst_we", bus.CTRL_SYNARRAY_WE, 0);
    chk("rst_addr", bus.CTRL_SYNARRAY_ADDR, 0);
    chk("rst_post", bus.CTRL_POST_NEURON_ADDRESS, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    tick();

    run_row(3, 5, 0, lat, nwr);
    chk("row3_done_cyc", lat, 193);
    chk("row3_writes", nwr, 64);
    chk("row3_first_rd", first_rd, 192);
    chk("row3_first_post", first_post, 0);
    chk("row3_last_wr", last_wr_addr, 255);
    chk("row3_last_post", last_wr_post, 252);
    chk("row3_last_wr_cyc", done_cyc - last_wr_cyc, 1);
    tick();

    run_row(0, 5, 1, lat, nwr);
    chk("gate_writes", nwr, 64);
    chk("gate_delayed", lat > 193, 1);
    chk("gate_last_wr", last_wr_addr, 63);
    tick();

    d_before = done_cnt;
    run_row(2, 9, 2, lat, nwr);
    chk("restart_done_cyc", lat, 193);
    chk("restart_writes", nwr, 64);
    chk("restart_last_wr", last_wr_addr, 191);
    repeat (60) tick();
    chk("restart_one_done", done_cnt - d_before, 1);

    d_before = done_cnt;
    run_row(4, 1, 4, lat, nwr);
    @(negedge clk);
    chk("abort_cs", bus.CTRL_SYNARRAY_CS, 0);
    chk("abort_busy", bus.BUSY, 0);
    chk("abort_no_done", done_cnt - d_before, 0);
    tick();
    run_row(0, 3, 0, lat, nwr);
    chk("post_rst_first", first_rd, 0);
    chk("post_rst_last", last_wr_addr, 63);
    chk("post_rst_cyc", lat, 193);
    tick();

    run_row(800, 5, 0, lat, nwr);
    chk("bad_row_cyc", lat, 1);
    chk("bad_row_writes", nwr, 0);
    tick();
    run_row(783, 5, 0, lat, nwr);
    chk("row783_first", first_rd, 50112);
    chk("row783_last", last_wr_addr, 50175);
    tick();

    run_row(5, 0, 0, lat, nwr);
    chk("zero_cnt_cyc", lat, SKIP ? 1 : 193);
    chk("zero_cnt_writes", nwr, SKIP ? 0 : 64);
    tick();

    d_before = done_cnt;
    bus.SPI_GATE_ACTIVITY_sync = 1'b1;
    bus.START = 1'b1;
    bus.PRE_NEUR_ADDR = 10'd1;
    tick();
    bus.START = 1'b0;
    bus.SPI_GATE_ACTIVITY_sync = 1'b0;
    repeat (5) tick();
    chk("gated_start_ignored", done_cnt - d_before, 0);

    for (int r = 0; r < 10; r++) begin
      run_row($urandom_range(0, 799), $urandom_range(0, 2),
              3, lat, nwr);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
endmodule
